// File: rtl/mod_exp_engine.sv
// Modular exponentiation engine: left-to-right square-and-multiply over
// all 16 exponent bits, each multiply done as 16-cycle interleaved shift-add.
module mod_exp_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] base,
    input  logic [15:0] exp,
    input  logic [15:0] mod,
    output logic [15:0] result,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic [19:0] cycles
);

    typedef enum logic [2:0] {IDLE, RED, SQR, MUL, FIN} state_t;

    state_t      state, state_nx;
    logic [15:0] b_q, e_q, n_q, x_q, r_q, acc_q;
    logic [15:0] op_a, op_b, acc_nx;
    logic [16:0] n_w, dbl, dbl_r, sum, sum_r;
    logic [3:0]  k_q, i_q;
    logic [19:0] cnt_q;
    logic        op_last;

    assign busy    = (state == RED) || (state == SQR) || (state == MUL);
    assign done    = (state == FIN);
    assign op_last = (k_q == 4'd0);

    // RED multiplies by 1 so a base >= n is folded into range first
    always_comb begin
        op_a = 16'd1;
        op_b = b_q;
        unique case (state)
            SQR: begin
                op_a = r_q;
                op_b = r_q;
            end
            MUL: begin
                op_a = r_q;
                op_b = x_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        n_w    = {1'b0, n_q};
        dbl    = {acc_q, 1'b0};
        dbl_r  = (dbl >= n_w) ? dbl - n_w : dbl;
        sum    = op_b[k_q] ? dbl_r + {1'b0, op_a} : dbl_r;
        sum_r  = (sum >= n_w) ? sum - n_w : sum;
        acc_nx = sum_r[15:0];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (mod < 16'd2) ? FIN : RED;
            RED:  if (op_last) state_nx = SQR;
            SQR: begin
                if (op_last) begin
                    if (e_q[i_q])            state_nx = MUL;
                    else if (i_q == 4'd0)    state_nx = FIN;
                end
            end
            MUL: if (op_last) state_nx = (i_q == 4'd0) ? FIN : SQR;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q    <= '0;
            e_q    <= '0;
            n_q    <= '0;
            x_q    <= '0;
            r_q    <= '0;
            acc_q  <= '0;
            k_q    <= '0;
            i_q    <= '0;
            cnt_q  <= '0;
            result <= '0;
            err    <= 1'b0;
            cycles <= '0;
        end else begin
            if (state == IDLE && start) begin
                b_q   <= base;
                e_q   <= exp;
                n_q   <= mod;
                acc_q <= '0;
                k_q   <= 4'd15;
                cnt_q <= '0;
                if (mod < 16'd2) begin
                    result <= '0;
                    err    <= 1'b1;
                    cycles <= '0;
                end else begin
                    err <= 1'b0;
                end
            end
            if (busy) begin
                cnt_q <= cnt_q + 20'd1;
                k_q   <= k_q - 4'd1;
                acc_q <= op_last ? 16'd0 : acc_nx;
                if (op_last) begin
                    unique case (state)
                        RED: begin
                            x_q <= acc_nx;
                            r_q <= 16'd1;
                            i_q <= 4'd15;
                        end
                        SQR: begin
                            r_q <= acc_nx;
                            if (!e_q[i_q] && i_q != 4'd0) i_q <= i_q - 4'd1;
                        end
                        MUL: begin
                            r_q <= acc_nx;
                            if (i_q != 4'd0) i_q <= i_q - 4'd1;
                        end
                        default: ;
                    endcase
                end
                if (state_nx == FIN) begin
                    result <= acc_nx;
                    cycles <= cnt_q + 20'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Bench for mod_exp_engine: directed vectors checked against an
// arithmetic square-and-multiply model and hand-computed literals.
module tb_mod_exp_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base = '0;
    logic [15:0] exp = '0;
    logic [15:0] mod = '0;
    logic [15:0] result;
    logic        done, busy, err;
    logic [19:0] cycles;

    int checks = 0;
    int errors = 0;

    logic [15:0] e_res;
    logic        e_err;
    int          e_cyc;
    bit          pending = 0;
    int          busy_cnt = 0;

    mod_exp_engine dut (
        .clk(clk), .rst(rst), .start(start),
        .base(base), .exp(exp), .mod(mod),
        .result(result), .done(done), .busy(busy),
        .err(err), .cycles(cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] b,
                                          input logic [15:0] e,
                                          input logic [15:0] m);
        longint r, x;
        if (m < 2) return 16'd0;
        r = 1;
        x = longint'(b) % longint'(m);
        for (int i = 15; i >= 0; i--) begin
            r = (r * r) % longint'(m);
            if (e[i]) r = (r * x) % longint'(m);
        end
        return r[15:0];
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (!pending) begin
                    check("spurious_done", 1, 0);
                end else begin
                    check("result", result, e_res);
                    check("err", err, e_err);
                    check("cycles", cycles, e_cyc);
                    check("busy_len", busy_cnt, e_cyc);
                    check("busy_at_done", busy, 0);
                end
                pending = 0;
            end
        end
    end

    task automatic start_op(input logic [15:0] b, input logic [15:0] e,
                            input logic [15:0] m, input int lit_res,
                            input int lit_cyc);
        @(negedge clk);
        e_res = model(b, e, m);
        e_err = (m < 2);
        e_cyc = (m < 2) ? 0 : 272 + 16 * $countones(e);
        if (lit_res >= 0) check("model_pin_res", e_res, lit_res);
        if (lit_cyc >= 0) check("model_pin_cyc", e_cyc, lit_cyc);
        busy_cnt = 0;
        pending  = 1;
        base  = b;
        exp   = e;
        mod   = m;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (pending && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pending) begin
            check("done_timeout", 0, 1);
            pending = 0;
        end
    endtask

    task automatic run(input logic [15:0] b, input logic [15:0] e,
                       input logic [15:0] m, input int lit_res,
                       input int lit_cyc);
        start_op(b, e, m, lit_res, lit_cyc);
        wait_done();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_cycles", cycles, 0);
        rst = 1'b0;

        run(16'd89, 16'd3, 16'd3127, 1394, 304);
        run(16'd1394, 16'd2011, 16'd3127, 89, 416);
        run(16'd65, 16'd17, 16'd3233, 2790, 304);
        run(16'd5000, 16'd0, 16'd3233, 1, 272);
        run(16'd6254, 16'd7, 16'd3127, 0, 320);
        run(16'd1234, 16'd5, 16'd1, 0, 0);
        run(16'd89, 16'd3, 16'd3127, 1394, 304);
        run(16'd7, 16'd9, 16'd0, 0, 0);
        run(16'd3, 16'd4, 16'd2, 1, 288);
        run(16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 528);
        run(16'hFFFE, 16'hFFFF, 16'hFFFD, -1, 528);
        run(16'd12345, 16'hA5A5, 16'd65521, -1, 400);

        start_op(16'd1394, 16'd2011, 16'd3127, 89, 416);
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            base  = 16'($urandom);
            exp   = 16'($urandom);
            mod   = 16'($urandom_range(0, 5));
            start = j[0];
        end
        start = 1'b0;
        wait_done();

        start_op(16'd89, 16'd3, 16'd3127, 1394, 304);
        repeat (60) @(negedge clk);
        check("busy_in_sqr", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        check("abort_cycles", cycles, 0);
        pending = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run(16'd89, 16'd3, 16'd3127, 1394, 304);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_exp_engine.md
MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-004 SHALL have port base, input, 16 bits: message or ciphertext, unsigned, any value.
REQ-005 SHALL have port exp, input, 16 bits: public or private exponent, unsigned.
REQ-006 SHALL have port mod, input, 16 bits: modulus n, unsigned.
REQ-007 SHALL have port result, output, 16 bits: base^exp mod n, held until next accepted start.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port err, output, 1 bit: set when n<2; held with result.
REQ-011 SHALL have port cycles, output, 20 bits: busy-cycle count of last operation, held.

Function
REQ-012 SHALL latch base, exp and mod on the rising edge where state=IDLE and start=1; inputs are ignored afterwards.
REQ-013 SHALL ignore start whenever state!=IDLE; there is no queueing.
REQ-014 SHALL implement states IDLE, RED, SQR, MUL, FIN.
- IDLE->RED on accepted start with n>=2.
- IDLE->FIN on accepted start with n<2.
REQ-015 SHALL perform every modular multiply a*b mod n as interleaved shift-add over b[15:0], MSB first, one bit per cycle, exactly 16 cycles.
- Per cycle: acc=2*acc, minus n if >=n; then if bit set, acc=acc+a, minus n if >=n.
- Intermediate width 17 bits; operands are always <n.
REQ-016 SHALL in RED compute x = 1*base mod n (16 cycles), then set r=1 and bit index i=15, and enter SQR.
REQ-017 SHALL in SQR compute r=r*r mod n (16 cycles).
- Then go to MUL if exp[i]=1.
- Else, if i=0 go to FIN; otherwise decrement i and stay in SQR.
REQ-018 SHALL in MUL compute r=r*x mod n (16 cycles); afterwards go to FIN if i=0, else decrement i and go to SQR.
REQ-019 SHALL process all 16 exponent bits including leading zeros, so busy time = 272 + 16*popcount(exp) cycles, independent of base and n.
REQ-020 SHALL in FIN, for one cycle: drive done=1, busy=0, result=r (or 0 with err=1 when n<2), cycles=counted busy cycles; then return to IDLE.
REQ-021 SHALL assert busy exactly in RED, SQR and MUL; for the n<2 path, busy never asserts and cycles=0.
REQ-022 SHALL produce result=1 for exp=0 with n>=2, and result=0 for base a multiple of n with exp>0.
REQ-023 SHALL clear err on the next accepted start with n>=2.
REQ-024 SHALL allow a start in the cycle after FIN, with no dead cycle beyond IDLE.

Reset
REQ-025 SHALL on rst=1, asynchronously and regardless of state, set state=IDLE and clear result, done, busy, err, cycles and all internal registers to 0.
REQ-026 SHALL abort an in-progress operation on reset with no done pulse; the first start after reset release is processed normally.

Verification
REQ-027 base=89, exp=3, mod=3127 -> result=1394, err=0, cycles=304, single done pulse, busy high for exactly 304 cycles.
REQ-028 base=1394, exp=2011, mod=3127 -> result=89, cycles=416.
REQ-029 base=65, exp=17, mod=3233 -> result=2790, cycles=304; then base=5000, exp=0, mod=3233 -> result=1, cycles=272.
REQ-030 mod=1 or mod=0 -> done one cycle after accept, result=0, err=1, busy never high, cycles=0; a following valid request clears err.
REQ-031 start pulsed repeatedly with other values during busy -> ignored; the first request's result is unchanged.
REQ-032 rst asserted mid-SQR -> outputs zero immediately, no done; a new start with base=89, exp=3, mod=3127 -> result=1394.
